// File: rtl/dp_pkg.sv
// Constants and helpers shared by the dot-product feeder and the engine.
package dp_pkg;

    localparam int ELEMENT_WIDTH = 32;
    localparam int NO_OF_UNITS   = 128;
    localparam int UNIT_SHIFT    = $clog2(NO_OF_UNITS);

    localparam logic [31:0] SIGN_MASK = 32'h8000_0000;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ENG_RST  = 2'd1;
    localparam logic [1:0] ST_STREAM   = 2'd2;
    localparam logic [1:0] ST_WAIT_FIN = 2'd3;

    function automatic logic [31:0] chunks_of(input logic [31:0] total);
        return total >> UNIT_SHIFT;
    endfunction

    // A job is runnable only if it is a non-empty whole number of chunks that fits the buffer.
    function automatic logic total_is_valid(input logic [31:0] total,
                                            input logic [31:0] max_chunks);
        return (total != 32'd0) &&
               (total[UNIT_SHIFT-1:0] == '0) &&
               (chunks_of(total) <= max_chunks);
    endfunction

endpackage

// File: rtl/dot_product_row_feeder_if.sv
// Controller, row-buffer and engine signals of the row feeder; master is the feeder side.
interface dot_product_row_feeder_if #(
    parameter int ELEMENT_WIDTH = dp_pkg::ELEMENT_WIDTH,
    parameter int NO_OF_UNITS   = dp_pkg::NO_OF_UNITS,
    parameter int ADDR_WIDTH    = 8
);
    localparam int ROW_W = ELEMENT_WIDTH * NO_OF_UNITS;

    logic                     start;
    logic [31:0]              total_in;
    logic                     busy;
    logic                     done;
    logic                     error;
    logic [ELEMENT_WIDTH-1:0] result;
    logic                     mem_rd_en;
    logic [ADDR_WIDTH-1:0]    mem_rd_addr;
    logic [ROW_W-1:0]         mem_rd_data_a;
    logic [ROW_W-1:0]         mem_rd_data_b;
    logic                     eng_reset;
    logic [31:0]              eng_total;
    logic [ROW_W-1:0]         eng_first_row;
    logic [ROW_W-1:0]         eng_second_row;
    logic                     eng_read_now;
    logic                     eng_finish;
    logic [ELEMENT_WIDTH-1:0] eng_dot_product;

    modport master (
        input  start, total_in, mem_rd_data_a, mem_rd_data_b, eng_finish, eng_dot_product,
        output busy, done, error, result, mem_rd_en, mem_rd_addr, eng_reset, eng_total,
               eng_first_row, eng_second_row, eng_read_now
    );

    modport slave (
        output start, total_in, mem_rd_data_a, mem_rd_data_b, eng_finish, eng_dot_product,
        input  busy, done, error, result, mem_rd_en, mem_rd_addr, eng_reset, eng_total,
               eng_first_row, eng_second_row, eng_read_now
    );

endinterface

// File: rtl/dp_chunk_sequencer.sv
// Slot timer and chunk counter: issues one row-buffer read per CHUNK_PERIOD slot and flags the load cycle.
module dp_chunk_sequencer #(
    parameter int ADDR_WIDTH   = 8,
    parameter int CHUNK_PERIOD = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH:0]   nchunks_i,
    output logic                  mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr_o,
    output logic                  load_o,
    output logic                  last_o
);
    localparam int SLOT_W = $clog2(CHUNK_PERIOD);

    logic                active_q, active_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [ADDR_WIDTH:0] chunk_q, chunk_d;
    logic                slot_end;

    assign slot_end      = active_q && (slot_q == SLOT_W'(CHUNK_PERIOD - 1));
    assign last_o        = slot_end && ((chunk_q + 1'b1) == nchunks_i);
    assign mem_rd_en_o   = active_q && (slot_q == '0);
    assign mem_rd_addr_o = chunk_q[ADDR_WIDTH-1:0];
    // Read data lands one cycle after the strobe, so the load happens in slot cycle 1.
    assign load_o        = active_q && (slot_q == SLOT_W'(1));

    always_comb begin
        active_d = active_q;
        slot_d   = slot_q;
        chunk_d  = chunk_q;
        if (start_i) begin
            active_d = 1'b1;
            slot_d   = '0;
            chunk_d  = '0;
        end else if (active_q) begin
            slot_d = slot_q + 1'b1;
            if (slot_end) begin
                slot_d  = '0;
                chunk_d = chunk_q + 1'b1;
                if (last_o) begin
                    active_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            slot_q   <= '0;
            chunk_q  <= '0;
        end else begin
            active_q <= active_d;
            slot_q   <= slot_d;
            chunk_q  <= chunk_d;
        end
    end

endmodule

// File: rtl/dot_product_row_feeder.sv
// Job FSM for the 128-lane dot-product engine: validates the request, resets the engine,
// streams row chunks through the sequencer and returns the engine result or a timeout error.
module dot_product_row_feeder
    import dp_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int CHUNK_PERIOD   = 4,
    parameter int ENG_RST_CYCLES = 2,
    parameter int TIMEOUT        = 4096
) (
    input  logic clk,
    input  logic reset,
    dot_product_row_feeder_if.master bus
);
    localparam int          ROW_W      = ELEMENT_WIDTH * NO_OF_UNITS;
    localparam int          RC_W       = $clog2(ENG_RST_CYCLES + 1);
    localparam int          TO_W       = $clog2(TIMEOUT + 1);
    localparam logic [31:0] MAX_CHUNKS = 32'd1 << ADDR_WIDTH;

    logic [1:0]               state_q, state_d;
    logic [RC_W-1:0]          rst_cnt_q, rst_cnt_d;
    logic [TO_W-1:0]          wait_cnt_q, wait_cnt_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;
    logic [ELEMENT_WIDTH-1:0] result_q, result_d;
    logic [31:0]              eng_total_q, eng_total_d;
    logic [ADDR_WIDTH:0]      nchunks_q, nchunks_d;
    logic                     fin_prev_q;
    logic [ROW_W-1:0]         row_a_q, row_b_q;
    logic                     read_now_q;

    logic        seq_start, seq_load, seq_last, seq_rd_en;
    logic [ADDR_WIDTH-1:0] seq_rd_addr;
    logic [31:0] total_chunks;
    logic        total_ok;
    logic        fin_rise;

    assign total_chunks = chunks_of(bus.total_in);
    assign total_ok     = total_is_valid(bus.total_in, MAX_CHUNKS);
    assign seq_start    = (state_q == ST_ENG_RST) && (rst_cnt_q == RC_W'(ENG_RST_CYCLES - 1));
    // fin_prev_q holds the previous cycle's level, so a finish already high on entry is no edge.
    assign fin_rise     = bus.eng_finish && !fin_prev_q;

    dp_chunk_sequencer #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .CHUNK_PERIOD (CHUNK_PERIOD)
    ) u_seq (
        .clk           (clk),
        .reset         (reset),
        .start_i       (seq_start),
        .nchunks_i     (nchunks_q),
        .mem_rd_en_o   (seq_rd_en),
        .mem_rd_addr_o (seq_rd_addr),
        .load_o        (seq_load),
        .last_o        (seq_last)
    );

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        result_d    = result_q;
        eng_total_d = eng_total_q;
        nchunks_d   = nchunks_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (total_ok) begin
                        eng_total_d = bus.total_in;
                        nchunks_d   = total_chunks[ADDR_WIDTH:0];
                        busy_d      = 1'b1;
                        rst_cnt_d   = '0;
                        state_d     = ST_ENG_RST;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_ENG_RST: begin
                rst_cnt_d = rst_cnt_q + 1'b1;
                if (seq_start) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (seq_last) begin
                    wait_cnt_d = '0;
                    state_d    = ST_WAIT_FIN;
                end
            end
            ST_WAIT_FIN: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (fin_rise) begin
                    result_d = bus.eng_dot_product;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else if (wait_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rst_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            result_q    <= '0;
            eng_total_q <= '0;
            nchunks_q   <= '0;
            fin_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            result_q    <= result_d;
            eng_total_q <= eng_total_d;
            nchunks_q   <= nchunks_d;
            fin_prev_q  <= bus.eng_finish;
        end
    end

    // Rows and the strobe update on the same edge so read_now marks fresh data.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_a_q    <= '0;
            row_b_q    <= '0;
            read_now_q <= 1'b0;
        end else begin
            read_now_q <= seq_load;
            if (seq_load) begin
                row_a_q <= bus.mem_rd_data_a;
                row_b_q <= bus.mem_rd_data_b;
            end
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.error          = error_q;
    assign bus.result         = result_q;
    assign bus.mem_rd_en      = seq_rd_en;
    assign bus.mem_rd_addr    = seq_rd_addr;
    assign bus.eng_reset      = reset || (state_q == ST_ENG_RST);
    assign bus.eng_total      = eng_total_q;
    assign bus.eng_first_row  = row_a_q;
    assign bus.eng_second_row = row_b_q;
    assign bus.eng_read_now   = read_now_q;

endmodule
